// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: states, opcodes,
// ALU op codes and datapath mux selects.
package mips_multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_RESET    = 4'd0,
    S_FETCH    = 4'd1,
    S_DECODE   = 4'd2,
    S_MEMADR   = 4'd3,
    S_MEMRD    = 4'd4,
    S_MEMWB    = 4'd5,
    S_MEMWR    = 4'd6,
    S_EXEC     = 4'd7,
    S_RTYPEWB  = 4'd8,
    S_BRANCH   = 4'd9,
    S_ADDIEXEC = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JUMP     = 4'd12,
    S_JAL      = 4'd13,
    S_JR       = 4'd14,
    S_HALT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [5:0] FUNCT_JR = 6'b001000;

  // Same encoding as the ALU control stage's op input.
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_RTYPE = 2'b10;

  localparam logic [1:0] DST_RT = 2'b00;
  localparam logic [1:0] DST_RD = 2'b01;
  localparam logic [1:0] DST_RA = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;
  localparam logic [1:0] PCSRC_REGA   = 2'b11;

  function automatic logic op_supported(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_ADDIU, OP_J, OP_JAL: op_supported = 1'b1;
      default:                         op_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_control.sv
// Moore control FSM for the multicycle MIPS datapath; 3-5 cycles per instruction.
// Stalls in FETCH/MEMRD/MEMWR until mem_ready; the only Mealy terms are mem_ready and the branch condition.
module mips_multicycle_control
  import mips_multicycle_control_pkg::*;
#(
  parameter bit ILLEGAL_TRAP = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       reg_write,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  state_t state_q;
  state_t state_nxt;
  logic   op_ok;

  assign op_ok = op_supported(opcode);
  assign state = state_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_RESET:  state_nxt = S_FETCH;
      S_FETCH:  if (mem_ready) state_nxt = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW:       state_nxt = S_MEMADR;
          OP_RTYPE:           state_nxt = (funct == FUNCT_JR) ? S_JR : S_EXEC;
          OP_BEQ, OP_BNE:     state_nxt = S_BRANCH;
          OP_ADDI, OP_ADDIU:  state_nxt = S_ADDIEXEC;
          OP_J:               state_nxt = S_JUMP;
          OP_JAL:             state_nxt = S_JAL;
          default:            state_nxt = ILLEGAL_TRAP ? S_HALT : S_FETCH;
        endcase
      end
      S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    if (mem_ready) state_nxt = S_MEMWB;
      S_MEMWR:    if (mem_ready) state_nxt = S_FETCH;
      S_EXEC:     state_nxt = S_RTYPEWB;
      S_ADDIEXEC: state_nxt = S_ADDIWB;
      S_HALT:     state_nxt = S_HALT;
      default:    state_nxt = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = DST_RT;
    mem_to_reg = WB_ALUOUT;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRCB_REGB;
    alu_op     = ALU_ADD;
    pc_source  = PCSRC_ALU;
    illegal    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        alu_op    = ALU_ADD;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculatively form the branch target into ALUOut.
        alu_src_b  = SRCB_IMM_SL2;
        alu_op     = ALU_ADD;
        illegal    = ~op_ok;
        instr_done = ~op_ok;
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        iord     = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = WB_MDR;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        mem_write  = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_REGB;
        alu_op    = ALU_RTYPE;
      end
      S_RTYPEWB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RD;
        mem_to_reg = WB_ALUOUT;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_src_b  = SRCB_REGB;
        alu_op     = ALU_SUB;
        pc_source  = PCSRC_ALUOUT;
        pc_write   = (opcode == OP_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        alu_op    = ALU_ADD;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        reg_dst    = DST_RT;
        mem_to_reg = WB_ALUOUT;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      S_JAL: begin
        pc_write   = 1'b1;
        pc_source  = PCSRC_JUMP;
        reg_write  = 1'b1;
        reg_dst    = DST_RA;
        mem_to_reg = WB_PC;
        instr_done = 1'b1;
      end
      S_JR: begin
        alu_src_a  = 1'b1;
        pc_write   = 1'b1;
        pc_source  = PCSRC_REGA;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Bench for mips_multicycle_control: directed and random instruction streams
// against a per-instruction cycle plan, with a second instance built to trap on illegal opcodes.
module tb_mips_multicycle_control;

  typedef struct packed {
    logic       pc_write;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;
  } ctl_t;

  typedef struct {
    logic [3:0] st;
    ctl_t       c;
    logic       rdy;
  } cyc_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write, alu_src_a, illegal, instr_done;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, alu_op, pc_source;
  logic [3:0] state;
  logic       t_pc_write, t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_write, t_alu_src_a;
  logic       t_illegal, t_instr_done;
  logic [1:0] t_reg_dst, t_mem_to_reg, t_alu_src_b, t_alu_op, t_pc_source;
  logic [3:0] t_state;

  mips_multicycle_control #(.ILLEGAL_TRAP(1'b0)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .pc_source(pc_source), .illegal(illegal), .instr_done(instr_done), .state(state)
  );

  mips_multicycle_control #(.ILLEGAL_TRAP(1'b1)) dut_trap (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(t_pc_write), .iord(t_iord), .mem_read(t_mem_read),
    .mem_write(t_mem_write), .ir_write(t_ir_write), .reg_dst(t_reg_dst),
    .mem_to_reg(t_mem_to_reg), .reg_write(t_reg_write), .alu_src_a(t_alu_src_a),
    .alu_src_b(t_alu_src_b), .alu_op(t_alu_op), .pc_source(t_pc_source),
    .illegal(t_illegal), .instr_done(t_instr_done), .state(t_state)
  );

  always #5 clock = ~clock;

  ctl_t obs, t_obs;
  assign obs = {pc_write, iord, mem_read, mem_write, ir_write, reg_dst, mem_to_reg,
                reg_write, alu_src_a, alu_src_b, alu_op, pc_source, illegal, instr_done};
  assign t_obs = {t_pc_write, t_iord, t_mem_read, t_mem_write, t_ir_write, t_reg_dst,
                  t_mem_to_reg, t_reg_write, t_alu_src_a, t_alu_src_b, t_alu_op,
                  t_pc_source, t_illegal, t_instr_done};

  int   errors = 0;
  int   checks = 0;
  bit   trap_halted = 1'b0;
  cyc_t plan[$];
  logic [5:0] legal_ops[9] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                               6'b001000, 6'b001001, 6'b000010, 6'b000011};
  logic [5:0] bad_ops[5]   = '{6'b111111, 6'b000001, 6'b010000, 6'b101010, 6'b001100};

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic add(input logic [3:0] st, input ctl_t c, input logic rdy);
    cyc_t e;
    e.st = st; e.c = c; e.rdy = rdy;
    plan.push_back(e);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction, from its opcode and wait counts.
  task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int fw, input int mw);
    ctl_t c;
    plan.delete();
    for (int i = 0; i < fw; i++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'b01;
      add(4'd1, c, 1'b0);
    end
    c = '0; c.mem_read = 1; c.alu_src_b = 2'b01; c.ir_write = 1; c.pc_write = 1;
    add(4'd1, c, 1'b1);
    c = '0; c.alu_src_b = 2'b11;
    if (!(op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                     6'b001000, 6'b001001, 6'b000010, 6'b000011})) begin
      c.illegal = 1; c.instr_done = 1;
    end
    add(4'd2, c, 1'($urandom_range(0, 1)));
    case (op)
      6'b100011, 6'b101011: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
        add(4'd3, c, 1'($urandom_range(0, 1)));
        if (op == 6'b100011) begin
          c = '0; c.mem_read = 1; c.iord = 1;
          for (int i = 0; i < mw; i++) add(4'd4, c, 1'b0);
          add(4'd4, c, 1'b1);
          c = '0; c.reg_write = 1; c.mem_to_reg = 2'b01; c.instr_done = 1;
          add(4'd5, c, 1'($urandom_range(0, 1)));
        end else begin
          c = '0; c.mem_write = 1; c.iord = 1;
          for (int i = 0; i < mw; i++) add(4'd6, c, 1'b0);
          c.instr_done = 1;
          add(4'd6, c, 1'b1);
        end
      end
      6'b000000: begin
        if (fn == 6'b001000) begin
          c = '0; c.alu_src_a = 1; c.pc_write = 1; c.pc_source = 2'b11; c.instr_done = 1;
          add(4'd14, c, 1'($urandom_range(0, 1)));
        end else begin
          c = '0; c.alu_src_a = 1; c.alu_op = 2'b10;
          add(4'd7, c, 1'($urandom_range(0, 1)));
          c = '0; c.reg_write = 1; c.reg_dst = 2'b01; c.instr_done = 1;
          add(4'd8, c, 1'($urandom_range(0, 1)));
        end
      end
      6'b000100, 6'b000101: begin
        c = '0; c.alu_src_a = 1; c.alu_op = 2'b01; c.pc_source = 2'b01; c.instr_done = 1;
        c.pc_write = (op == 6'b000100) ? z : ~z;
        add(4'd9, c, 1'($urandom_range(0, 1)));
      end
      6'b001000, 6'b001001: begin
        c = '0; c.alu_src_a = 1; c.alu_src_b = 2'b10;
        add(4'd10, c, 1'($urandom_range(0, 1)));
        c = '0; c.reg_write = 1; c.instr_done = 1;
        add(4'd11, c, 1'($urandom_range(0, 1)));
      end
      6'b000010, 6'b000011: begin
        c = '0; c.pc_write = 1; c.pc_source = 2'b10; c.instr_done = 1;
        if (op == 6'b000011) begin
          c.reg_write = 1; c.reg_dst = 2'b10; c.mem_to_reg = 2'b10;
        end
        add((op == 6'b000011) ? 4'd13 : 4'd12, c, 1'($urandom_range(0, 1)));
      end
      default: begin
      end
    endcase
  endtask

  task automatic check_cycle(input cyc_t e, input string ph);
    chk({ph, "_state"}, 32'(state), 32'(e.st));
    chk({ph, "_ctl"}, 32'(obs), 32'(e.c));
    chk({ph, "_rd_wr_excl"}, 32'(mem_read & mem_write), 32'd0);
    if (trap_halted) begin
      chk({ph, "_trap_state"}, 32'(t_state), 32'd15);
      chk({ph, "_trap_ctl"}, 32'(t_obs), 32'd0);
    end else begin
      chk({ph, "_trap_state"}, 32'(t_state), 32'(e.st));
      chk({ph, "_trap_ctl"}, 32'(t_obs), 32'(e.c));
      if (e.c.illegal) trap_halted = 1'b1;
    end
  endtask

  task automatic check_reset_zero(input string ph);
    chk({ph, "_state"}, 32'(state), 32'd0);
    chk({ph, "_ctl"}, 32'(obs), 32'd0);
    chk({ph, "_trap_state"}, 32'(t_state), 32'd0);
    chk({ph, "_trap_ctl"}, 32'(t_obs), 32'd0);
  endtask

  // Entered #1 after a rising edge; leaves #1 after the edge that starts the next instruction.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input int fw, input int mw, input int abort_at);
    int ab;
    build(op, fn, z, fw, mw);
    ab = (abort_at == -2) ? $urandom_range(0, plan.size() - 1) : abort_at;
    opcode = op; funct = fn; zero = z;
    for (int i = 0; i < plan.size(); i++) begin
      mem_ready = plan[i].rdy;
      if (i == ab) begin
        #1;
        check_cycle(plan[i], "pre_rst");
        reset = 1'b0;
        #1;
        check_reset_zero("rst_async");
        trap_halted = 1'b0;
        @(negedge clock);
        check_reset_zero("rst_hold");
        @(posedge clock); #1;
        reset = 1'b1;
        @(negedge clock);
        check_reset_zero("rst_release");
        @(posedge clock); #1;
        return;
      end
      @(negedge clock);
      check_cycle(plan[i], $sformatf("op%02h_c%0d", op, i));
      @(posedge clock); #1;
    end
  endtask

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    #1 reset = 1'b0;
    #2;
    check_reset_zero("por");
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    check_reset_zero("por_release");
    @(posedge clock); #1;

    run_instr(6'b000000, 6'b100000, 1'b0, 0, 0, -1);  // ADD
    run_instr(6'b100011, 6'b000000, 1'b0, 1, 3, -1);  // LW, 3 memory waits
    run_instr(6'b101011, 6'b000000, 1'b0, 0, 0, -1);  // SW
    run_instr(6'b000100, 6'b000000, 1'b1, 0, 0, -1);  // BEQ taken
    run_instr(6'b000101, 6'b000000, 1'b1, 0, 0, -1);  // BNE not taken
    run_instr(6'b000101, 6'b000000, 1'b0, 2, 0, -1);  // BNE taken
    run_instr(6'b000011, 6'b000000, 1'b0, 0, 0, -1);  // JAL
    run_instr(6'b111111, 6'b000000, 1'b0, 0, 0, -1);  // illegal: trap instance halts
    run_instr(6'b000010, 6'b000000, 1'b0, 0, 0, -1);  // J while trap instance is held
    run_instr(6'b001000, 6'b000000, 1'b0, 0, 0, -1);  // ADDI
    run_instr(6'b100011, 6'b000000, 1'b0, 0, 3, 4);   // reset in second MEMRD cycle
    run_instr(6'b000000, 6'b001000, 1'b0, 0, 0, -1);  // JR
    run_instr(6'b001001, 6'b000000, 1'b0, 0, 0, -1);  // ADDIU

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 9) == 0) op = bad_ops[$urandom_range(0, 4)];
      else op = legal_ops[$urandom_range(0, 8)];
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      run_instr(op, fn, 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                $urandom_range(0, 3), ($urandom_range(0, 15) == 0) ? -2 : -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_control.md
Name: mips_multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback steps.
- Drives every datapath mux and write-enable, including the 2-bit alu_op consumed by the ALU control stage.
- Sits between the instruction register (opcode/funct) and the datapath; waits on a memory ready handshake.

Parameters:
- ILLEGAL_TRAP, 0, 0 = an unsupported opcode returns to FETCH; 1 = it enters HALT until reset.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory access complete this cycle
- pc_write  out  1  PC load enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  out  1  memory read request
- mem_write  out  1  memory write request
- ir_write  out  1  IR load enable
- reg_dst  out  2  register write address: 00 = rt, 01 = rd, 10 = $31
- mem_to_reg  out  2  register write data: 00 = ALUOut, 01 = MDR, 10 = PC
- reg_write  out  1  register file write enable
- alu_src_a  out  1  ALU A input: 0 = PC, 1 = register A
- alu_src_b  out  2  ALU B input: 00 = register B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2
- alu_op  out  2  00 = add, 01 = subtract, 10 = R-type (decode funct)
- pc_source  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = register A
- illegal  out  1  unsupported opcode seen in DECODE
- instr_done  out  1  last cycle of the current instruction
- state  out  4  current state, debug only

Behaviour:
- State register: 4 bits, async-cleared to RESET (0) when reset is low; it is the only storage.
- Outputs are combinational from state (Moore). The only Mealy terms are mem_ready gating and the zero/opcode term in BRANCH.
- Every output not listed for a state is 0.
- Reset timing: in RESET all outputs are 0. After reset deasserts, the first rising edge moves RESET to FETCH.
- Reset mid-instruction: state goes to RESET immediately and all outputs drop to 0 combinationally; no partial write may be issued.
- Supported opcodes: R-type 000000, LW 100011, SW 101011, BEQ 000100, BNE 000101, ADDI 001000, ADDIU 001001, J 000010, JAL 000011.
- States, control values and transitions:
  - FETCH (1): mem_read=1, alu_src_b=01, alu_op=00, ir_write=pc_write=mem_ready. Stays while mem_ready=0; otherwise goes to DECODE.
  - DECODE (2): alu_src_b=11, alu_op=00 (branch target computed into ALUOut). Next state by opcode:
    - LW/SW -> MEMADR
    - R-type with funct 001000 -> JR; other R-type -> EXEC
    - BEQ/BNE -> BRANCH
    - ADDI/ADDIU -> ADDIEXEC
    - J -> JUMP; JAL -> JAL
    - anything else: illegal=1, instr_done=1, next is FETCH, or HALT if ILLEGAL_TRAP=1.
  - MEMADR (3): alu_src_a=1, alu_src_b=10, alu_op=00. LW -> MEMRD; SW -> MEMWR.
  - MEMRD (4): mem_read=1, iord=1. Waits on mem_ready, then MEMWB.
  - MEMWB (5): reg_write=1, reg_dst=00, mem_to_reg=01, instr_done=1. Next FETCH.
  - MEMWR (6): mem_write=1, iord=1. Waits on mem_ready; instr_done=mem_ready; then FETCH.
  - EXEC (7): alu_src_a=1, alu_src_b=00, alu_op=10. Next RTYPEWB.
  - RTYPEWB (8): reg_write=1, reg_dst=01, mem_to_reg=00, instr_done=1. Next FETCH.
  - BRANCH (9): alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01, instr_done=1. pc_write = zero for BEQ, ~zero for BNE. Next FETCH.
  - ADDIEXEC (10): alu_src_a=1, alu_src_b=10, alu_op=00. Next ADDIWB.
  - ADDIWB (11): reg_write=1, reg_dst=00, mem_to_reg=00, instr_done=1. Next FETCH.
  - JUMP (12): pc_write=1, pc_source=10, instr_done=1. Next FETCH.
  - JAL (13): JUMP controls plus reg_write=1, reg_dst=10, mem_to_reg=10. Next FETCH.
  - JR (14): alu_src_a=1, pc_write=1, pc_source=11, instr_done=1. Next FETCH.
  - HALT (15): all outputs 0. Held until reset.
- Mutual exclusion: mem_read and mem_write are never both 1.
- mem_ready: ignored outside FETCH, MEMRD and MEMWR. In a wait state, a mem_ready high on the first cycle still takes exactly one cycle.
- opcode and funct are sampled only in DECODE, MEMADR and BRANCH; the IR is stable there.
- Cycle counts with zero wait states:
  - R-type, ADDI: 4
  - LW: 5
  - SW: 4
  - BEQ/BNE, J, JAL, JR: 3

Decomposition:
- Shared package/header holds:
  - state encodings
  - opcode constants
  - funct JR constant
  - alu_op codes (00 add, 01 sub, 10 R-type; identical to the ALU control's op input)
  - mux select codes for reg_dst, mem_to_reg, alu_src_b and pc_source
- Single module: a next-state block plus an output decode block. No sub-module is needed.

Test Plan:
- Reset low mid-MEMRD -> state=0 and all outputs 0 in the same cycle. Reset release -> FETCH after 1 edge.
- ADD instruction, opcode 000000 funct 100000, mem_ready=1 -> states 1,2,7,8. alu_op=10 in EXEC; reg_write=1, reg_dst=01 in RTYPEWB; instr_done on cycle 4.
- LW opcode 100011, mem_ready held low for 3 cycles in MEMRD -> stays in state 4 for 4 cycles, then MEMWB with mem_to_reg=01, reg_write=1.
- BEQ with zero=1 -> pc_write=1, pc_source=01, alu_op=01 in BRANCH. BNE with zero=1 -> pc_write=0.
- JAL opcode 000011 -> states 1,2,13. In JAL: pc_write=1, reg_dst=10, mem_to_reg=10.
- Opcode 111111 -> illegal=1 in DECODE. ILLEGAL_TRAP=0 returns to FETCH; ILLEGAL_TRAP=1 holds state=15 until reset.
